// File: rtl/ch9350_report_pkg.sv
// Shared constants and state encoding for the CH9350 keyboard frame parser.
`timescale 1ns/1ps
package ch9350_report_pkg;

  localparam logic [7:0] HDR0_BYTE    = 8'h57;
  localparam logic [7:0] HDR1_BYTE    = 8'hAB;
  localparam logic [7:0] CMD_KEYB     = 8'h88;
  localparam logic [7:0] LEN_KEYB     = 8'h0B;
  localparam int         REPORT_BYTES = 8;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_CMD,
    ST_LEN,
    ST_TYPE,
    ST_REP,
    ST_SERIAL,
    ST_CSUM
  } state_t;

endpackage

// File: rtl/ch9350_report_if.sv
// Byte-stream input, report output and debug strobes of the CH9350 frame parser.
`timescale 1ns/1ps
interface ch9350_report_if;

  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic [63:0] o_report;
  logic        o_report_valid;
  logic        i_report_ready;
  logic        o_err_frame;
  logic        o_err_sum;
  logic        o_overrun;

  // The parser side.
  modport slave (
    input  i_byte, i_byte_valid, i_report_ready,
    output o_byte_ready, o_report, o_report_valid,
    output o_err_frame, o_err_sum, o_overrun
  );

  // The UART receiver / keymap side.
  modport master (
    output i_byte, i_byte_valid, i_report_ready,
    input  o_byte_ready, o_report, o_report_valid,
    input  o_err_frame, o_err_sum, o_overrun
  );

endinterface

// File: rtl/ch9350_report.sv
// Validates CH9350 keyboard status frames and holds the last good HID boot
// report in a single-entry valid/ready register.
`timescale 1ns/1ps
module ch9350_report
  import ch9350_report_pkg::*;
#(
    parameter int GAP_CYCLES = 12000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ch9350_report_if.slave bus
);

    localparam int TW = $clog2(GAP_CYCLES + 1);

    state_t        state;
    logic [63:0]   staging;
    logic [7:0]    sum;
    logic [2:0]    rep_idx;
    logic [TW-1:0] gap_cnt;
    logic [63:0]   report;
    logic          report_valid;
    logic          err_frame;
    logic          err_sum;
    logic          overrun;

    logic accept;
    logic handshake;
    logic commit;
    logic gap_hit;

    // The parser never stalls, so every valid byte is an accepted byte.
    assign accept    = bus.i_byte_valid;
    assign handshake = report_valid & bus.i_report_ready;
    assign commit    = accept && (state == ST_CSUM) && (bus.i_byte == sum);
    assign gap_hit   = (gap_cnt == TW'(GAP_CYCLES - 1));

    // NOTE: all state lives in one clocked block with non-blocking assignments,
    // so every read below sees the pre-edge value regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_HDR0;
            staging      <= '0;
            sum          <= '0;
            rep_idx      <= '0;
            gap_cnt      <= '0;
            report       <= '0;
            report_valid <= 1'b0;
            err_frame    <= 1'b0;
            err_sum      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            err_sum   <= 1'b0;
            overrun   <= 1'b0;

            if (accept) begin
                gap_cnt <= '0;
                unique case (state)
                    ST_HDR0: if (bus.i_byte == HDR0_BYTE) state <= ST_HDR1;
                    ST_HDR1: begin
                        if (bus.i_byte == HDR1_BYTE)      state <= ST_CMD;
                        else if (bus.i_byte != HDR0_BYTE) state <= ST_HDR0;
                    end
                    ST_CMD: begin
                        if (bus.i_byte == CMD_KEYB) begin
                            state <= ST_LEN;
                        end else begin
                            state     <= ST_HDR0;
                            err_frame <= 1'b1;
                        end
                    end
                    ST_LEN: begin
                        if (bus.i_byte == LEN_KEYB) begin
                            state   <= ST_TYPE;
                            sum     <= '0;
                            rep_idx <= '0;
                        end else begin
                            state     <= ST_HDR0;
                            err_frame <= 1'b1;
                        end
                    end
                    ST_TYPE: state <= ST_REP;
                    ST_REP: begin
                        // Byte R0 ends up in the top byte after eight shifts.
                        staging <= {staging[55:0], bus.i_byte};
                        sum     <= sum + bus.i_byte;
                        rep_idx <= rep_idx + 3'd1;
                        if (rep_idx == 3'(REPORT_BYTES - 1)) state <= ST_SERIAL;
                    end
                    ST_SERIAL: state <= ST_CSUM;
                    ST_CSUM: begin
                        if (bus.i_byte != sum) err_sum <= 1'b1;
                        state <= ST_HDR0;
                    end
                    default: state <= ST_HDR0;
                endcase
            end else if (state != ST_HDR0) begin
                if (gap_hit) begin
                    state     <= ST_HDR0;
                    gap_cnt   <= '0;
                    err_frame <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end

            // A commit wins over a same-cycle handshake: the new report replaces
            // the consumed one without counting as an overrun.
            if (commit) begin
                report       <= staging;
                report_valid <= 1'b1;
                overrun      <= report_valid & ~bus.i_report_ready;
            end else if (handshake) begin
                report_valid <= 1'b0;
            end
        end
    end

    assign bus.o_byte_ready   = 1'b1;
    assign bus.o_report       = report;
    assign bus.o_report_valid = report_valid;
    assign bus.o_err_frame    = err_frame;
    assign bus.o_err_sum      = err_sum;
    assign bus.o_overrun      = overrun;

endmodule

// File: tb/tb_ch9350_report.sv
// Scoreboard bench for ch9350_report: directed frames push expected reports and
// strobes into queues; a monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_ch9350_report;

    localparam int          GAP   = 12000;
    localparam logic [63:0] RPT_A = 64'h0200_0400_0000_0000;
    localparam logic [63:0] RPT_B = 64'h0200_0500_0000_0000;

    typedef enum logic [1:0] {EV_FRAME, EV_SUM, EV_OVERRUN} ev_t;

    logic clk = 1'b0;
    logic rst;

    ch9350_report_if bus ();

    ch9350_report #(.GAP_CYCLES(GAP)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] rpt_q[$];
    ev_t         ev_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic pop_event(input ev_t got);
        ev_t exp;
        if (ev_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_strobe: got %s expected none at %0t", got.name(), $time);
        end else begin
            exp = ev_q.pop_front();
            check("strobe_kind", 64'(got), 64'(exp));
        end
    endtask

    // Outputs and inputs are both stable at the falling edge, so a handshake
    // seen here is exactly the one the DUT samples on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_err_frame) pop_event(EV_FRAME);
            if (bus.o_err_sum)   pop_event(EV_SUM);
            if (bus.o_overrun)   pop_event(EV_OVERRUN);
            if (bus.o_report_valid && bus.i_report_ready) begin
                if (rpt_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_report: got %h expected none at %0t", bus.o_report, $time);
                end else begin
                    check("report_data", bus.o_report, rpt_q.pop_front());
                end
            end
        end
    end

    // NOTE: inputs change 1 ns after the rising edge, well clear of both the
    // DUT sampling edge and the monitor's falling-edge sample.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        tick();
        bus.i_byte_valid = 1'b0;
    endtask

    // Keyboard frame with R0=02, R2 variable, other report bytes 00, SERIAL=01.
    task automatic send_range(input logic [7:0] r2, input logic [7:0] csum, input int lo, input int hi);
        logic [7:0] f [15];
        f = '{8'h57, 8'hAB, 8'h88, 8'h0B, 8'h10, 8'h02, 8'h00, r2,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, csum};
        for (int i = lo; i <= hi; i++) send(f[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"},    64'(bus.o_report_valid), 64'd0);
        check({tag, "_report"},   bus.o_report,            64'd0);
        check({tag, "_ready"},    64'(bus.o_byte_ready),   64'd1);
        check({tag, "_strobes"},  64'({bus.o_err_frame, bus.o_err_sum, bus.o_overrun}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.i_byte         = 8'h00;
        bus.i_byte_valid   = 1'b0;
        bus.i_report_ready = 1'b1;
        idle(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Good frame, report visible the cycle after CSUM.
        rpt_q.push_back(RPT_A);
        send_range(8'h04, 8'h06, 0, 14);
        check("good_latency", 64'(bus.o_report_valid), 64'd1);
        check("good_report",  bus.o_report,            RPT_A);
        idle(3);

        // Bad checksum.
        ev_q.push_back(EV_SUM);
        send_range(8'h04, 8'h07, 0, 14);
        check("badsum_valid", 64'(bus.o_report_valid), 64'd0);
        idle(3);
        check("badsum_valid_later", 64'(bus.o_report_valid), 64'd0);

        // Garbage and a repeated 0x57 before the header completes.
        rpt_q.push_back(RPT_A);
        send(8'h00);
        send(8'h57);
        send(8'h57);
        send(8'hAB);
        send_range(8'h04, 8'h06, 2, 14);
        check("resync_valid", 64'(bus.o_report_valid), 64'd1);
        idle(3);

        // Wrong command byte, then wrong length byte.
        ev_q.push_back(EV_FRAME);
        send(8'h57); send(8'hAB); send(8'h89);
        idle(2);
        ev_q.push_back(EV_FRAME);
        send(8'h57); send(8'hAB); send(8'h88); send(8'h0C);
        idle(2);

        // Stall after R3 long enough to time out, then a clean frame.
        ev_q.push_back(EV_FRAME);
        send_range(8'h04, 8'h06, 0, 8);
        idle(GAP + 2);
        rpt_q.push_back(RPT_A);
        send_range(8'h04, 8'h06, 0, 14);
        idle(3);

        // One idle cycle short of the timeout: the frame must survive.
        rpt_q.push_back(RPT_A);
        send_range(8'h04, 8'h06, 0, 8);
        idle(GAP - 1);
        send_range(8'h04, 8'h06, 9, 14);
        check("gap_edge_valid", 64'(bus.o_report_valid), 64'd1);
        idle(3);

        // Back-to-back frames with the consumer stalled.
        bus.i_report_ready = 1'b0;
        rpt_q.push_back(RPT_B);
        ev_q.push_back(EV_OVERRUN);
        send_range(8'h04, 8'h06, 0, 14);
        check("ovr_first_report", bus.o_report, RPT_A);
        send_range(8'h05, 8'h07, 0, 14);
        check("ovr_second_report", bus.o_report,              RPT_B);
        check("ovr_strobe",        64'(bus.o_overrun),        64'd1);
        idle(2);
        check("ovr_hold_valid",    64'(bus.o_report_valid),   64'd1);
        check("ovr_hold_report",   bus.o_report,              RPT_B);
        bus.i_report_ready = 1'b1;
        tick();
        check("ovr_drain_valid",   64'(bus.o_report_valid),   64'd0);
        idle(2);

        // Reset in the middle of the report bytes, then a clean frame.
        send_range(8'h04, 8'h06, 0, 7);
        rst = 1'b1;
        tick();
        check_idle_outputs("midrst");
        tick();
        rst = 1'b0;
        rpt_q.push_back(RPT_A);
        send_range(8'h04, 8'h06, 0, 14);
        check("postrst_report", bus.o_report, RPT_A);
        idle(4);

        check("report_queue_drained", 64'(rpt_q.size()), 64'd0);
        check("event_queue_drained",  64'(ev_q.size()),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
